// File: rtl/timer_pwm_block_pkg.sv
// Shared constants and configuration struct for the timer/PWM peripheral.
// Register addresses, data width and the packed config bundle.
package timer_pwm_block_pkg;

    localparam int DW = 16;
    localparam int AW = 2;

    localparam logic [AW-1:0] ADDR_MAX  = 2'd0;
    localparam logic [AW-1:0] ADDR_PWM  = 2'd1;
    localparam logic [AW-1:0] ADDR_STOP = 2'd2;

    typedef struct packed {
        logic [DW-1:0] max_count;
        logic [DW-1:0] pwm_count;
        logic [DW-1:0] stop_count;
    } cfg_t;

endpackage

// File: rtl/timer_pwm_block_regs.sv
// Register file for period, duty and run length; one-cycle write latency.
// No backpressure: a write is accepted at every edge with iWe high.
module timer_pwm_block_regs
    import timer_pwm_block_pkg::*;
(
    input  logic          iCLK,
    input  logic          iRSTn,
    input  logic [AW-1:0] iAddr,
    input  logic          iWe,
    input  logic [DW-1:0] iWdata,
    output cfg_t          cfg
);

    cfg_t cfg_d, cfg_q;

    always_comb begin
        cfg_d = cfg_q;
        if (iWe) begin
            case (iAddr)
                ADDR_MAX:  cfg_d.max_count  = iWdata;
                ADDR_PWM:  cfg_d.pwm_count  = iWdata;
                ADDR_STOP: cfg_d.stop_count = iWdata;
                default:   cfg_d = cfg_q;
            endcase
        end
    end

    always_ff @(posedge iCLK) begin
        if (!iRSTn) begin
            cfg_q <= '0;
        end else begin
            cfg_q <= cfg_d;
        end
    end

    assign cfg = cfg_q;

endmodule

// File: rtl/timer_pwm_block.sv
// Timer/PWM generator: counts periods of max_count+1 cycles after a start pulse.
// Outputs decode registered state only (valid the cycle after start); no backpressure.
module timer_pwm_block
    import timer_pwm_block_pkg::*;
(
    input  logic          iCLK,
    input  logic          iRSTn,
    input  logic [AW-1:0] iAddr,
    input  logic          iWe,
    input  logic [DW-1:0] iWdata,
    input  logic          iStart,
    output logic          oPWM,
    output logic          oTimer_End
);

    cfg_t          cfg;
    logic          run_d, run_q;
    logic [DW-1:0] cnt_d, cnt_q;
    logic [DW-1:0] pcnt_d, pcnt_q;
    logic          period_end;
    logic          last_period;

    timer_pwm_block_regs u_regs (
        .iCLK   (iCLK),
        .iRSTn  (iRSTn),
        .iAddr  (iAddr),
        .iWe    (iWe),
        .iWdata (iWdata),
        .cfg    (cfg)
    );

    assign period_end  = (cnt_q == cfg.max_count);
    assign last_period = (cfg.stop_count != '0) && (pcnt_q == cfg.stop_count - DW'(1));

    always_comb begin
        run_d  = run_q;
        cnt_d  = cnt_q;
        pcnt_d = pcnt_q;
        // A start request overrides any period-end or stop decision.
        if (iStart) begin
            run_d  = 1'b1;
            cnt_d  = '0;
            pcnt_d = '0;
        end else if (run_q) begin
            if (period_end) begin
                cnt_d  = '0;
                if (last_period) begin
                    run_d  = 1'b0;
                    pcnt_d = '0;
                end else begin
                    pcnt_d = pcnt_q + DW'(1);
                end
            end else begin
                cnt_d = cnt_q + DW'(1);
            end
        end
    end

    always_ff @(posedge iCLK) begin
        if (!iRSTn) begin
            run_q  <= 1'b0;
            cnt_q  <= '0;
            pcnt_q <= '0;
        end else begin
            run_q  <= run_d;
            cnt_q  <= cnt_d;
            pcnt_q <= pcnt_d;
        end
    end

    assign oPWM       = run_q && (cnt_q < cfg.pwm_count);
    assign oTimer_End = run_q && period_end;

endmodule

// File: tb/tb_timer_pwm_block.sv
// Directed bench for timer_pwm_block: drives writes/starts and checks the
// PWM and period-end waveforms against hand-computed counts and positions.
module tb_timer_pwm_block;

    logic        iCLK;
    logic        iRSTn;
    logic [1:0]  iAddr;
    logic        iWe;
    logic [15:0] iWdata;
    logic        iStart;
    logic        oPWM;
    logic        oTimer_End;

    int n_checks;
    int n_pass;

    bit pwm_v [0:63];
    bit end_v [0:63];
    int pwm_cnt;
    int end_cnt;

    timer_pwm_block dut (
        .iCLK       (iCLK),
        .iRSTn      (iRSTn),
        .iAddr      (iAddr),
        .iWe        (iWe),
        .iWdata     (iWdata),
        .iStart     (iStart),
        .oPWM       (oPWM),
        .oTimer_End (oTimer_End)
    );

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge iCLK);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [15:0] d);
        iAddr  = a;
        iWdata = d;
        iWe    = 1'b1;
        tick();
        iWe    = 1'b0;
    endtask

    task automatic start();
        iStart = 1'b1;
        tick();
        iStart = 1'b0;
    endtask

    task automatic do_reset();
        iRSTn = 1'b0;
        tick();
        iRSTn = 1'b1;
    endtask

    // Record n cycles of outputs, beginning with the current cycle.
    task automatic capture(input int n);
        pwm_cnt = 0;
        end_cnt = 0;
        for (int i = 0; i < 64; i++) begin
            pwm_v[i] = 1'b0;
            end_v[i] = 1'b0;
        end
        for (int i = 0; i < n; i++) begin
            pwm_v[i] = oPWM;
            end_v[i] = oTimer_End;
            if (oPWM) pwm_cnt++;
            if (oTimer_End) end_cnt++;
            tick();
        end
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        iRSTn    = 1'b0;
        iAddr    = 2'd0;
        iWe      = 1'b0;
        iWdata   = 16'd0;
        iStart   = 1'b0;

        // Reset state
        tick();
        chk("rst_pwm", int'(oPWM), 0);
        chk("rst_end", int'(oTimer_End), 0);
        iRSTn = 1'b1;
        tick();
        chk("idle_pwm", int'(oPWM), 0);
        chk("idle_end", int'(oTimer_End), 0);

        // Continuous run: max=15, pwm=5, stop=0
        wr(2'd0, 16'd15);
        wr(2'd1, 16'd5);
        wr(2'd2, 16'd0);
        start();
        capture(40);
        chk("cont_pwm_cnt", pwm_cnt, 15);
        chk("cont_end_cnt", end_cnt, 2);
        chk("cont_pwm4", int'(pwm_v[4]), 1);
        chk("cont_pwm5", int'(pwm_v[5]), 0);
        chk("cont_end14", int'(end_v[14]), 0);
        chk("cont_end15", int'(end_v[15]), 1);
        chk("cont_pwm16", int'(pwm_v[16]), 1);
        chk("cont_end31", int'(end_v[31]), 1);

        // Now at cnt=8; advance to cnt=1 (cycle 49) and restart there
        for (int i = 0; i < 9; i++) tick();
        chk("pre_restart_pwm", int'(oPWM), 1);
        start();
        capture(16);
        chk("restart_pwm_cnt", pwm_cnt, 5);
        chk("restart_pwm4", int'(pwm_v[4]), 1);
        chk("restart_pwm5", int'(pwm_v[5]), 0);
        chk("restart_end14", int'(end_v[14]), 0);
        chk("restart_end15", int'(end_v[15]), 1);

        // Reset mid-run stops the timer and clears the registers
        do_reset();
        chk("midrst_pwm", int'(oPWM), 0);
        chk("midrst_end", int'(oTimer_End), 0);
        tick();
        chk("midrst_idle_end", int'(oTimer_End), 0);
        // Cleared registers: max=0 -> end every cycle, pwm=0 -> low, stop=0 -> continuous
        start();
        chk("zero_regs_end0", int'(oTimer_End), 1);
        chk("zero_regs_pwm0", int'(oPWM), 0);
        for (int i = 0; i < 3; i++) tick();
        chk("zero_regs_end3", int'(oTimer_End), 1);
        do_reset();

        // Bounded run: max=10, pwm=6, stop=2 -> 22 cycles
        wr(2'd0, 16'd10);
        wr(2'd1, 16'd6);
        wr(2'd2, 16'd2);
        start();
        capture(30);
        chk("bnd_pwm_cnt", pwm_cnt, 12);
        chk("bnd_end_cnt", end_cnt, 2);
        chk("bnd_pwm5", int'(pwm_v[5]), 1);
        chk("bnd_pwm6", int'(pwm_v[6]), 0);
        chk("bnd_end10", int'(end_v[10]), 1);
        chk("bnd_pwm11", int'(pwm_v[11]), 1);
        chk("bnd_end21", int'(end_v[21]), 1);
        chk("bnd_pwm22", int'(pwm_v[22]), 0);
        chk("bnd_end22", int'(end_v[22]), 0);

        // pwm=0: never high
        wr(2'd1, 16'd0);
        start();
        capture(30);
        chk("pwm0_pwm_cnt", pwm_cnt, 0);
        chk("pwm0_end_cnt", end_cnt, 2);

        // pwm=20 > max=10: high for the whole 22-cycle run
        wr(2'd1, 16'd20);
        start();
        capture(30);
        chk("pwm20_pwm_cnt", pwm_cnt, 22);
        chk("pwm20_pwm21", int'(pwm_v[21]), 1);
        chk("pwm20_pwm22", int'(pwm_v[22]), 0);

        // max=0, stop=3: end high 3 cycles then stop
        wr(2'd0, 16'd0);
        wr(2'd2, 16'd3);
        start();
        capture(10);
        chk("max0_end_cnt", end_cnt, 3);
        chk("max0_end2", int'(end_v[2]), 1);
        chk("max0_end3", int'(end_v[3]), 0);
        chk("max0_pwm_cnt", pwm_cnt, 3);

        // Address 3 writes must change nothing
        wr(2'd3, 16'd0);
        start();
        capture(10);
        chk("addr3a_end_cnt", end_cnt, 3);
        chk("addr3a_pwm_cnt", pwm_cnt, 3);
        wr(2'd3, 16'd7);
        start();
        capture(10);
        chk("addr3b_end_cnt", end_cnt, 3);
        chk("addr3b_end0", int'(end_v[0]), 1);

        // Write max=4 on the same edge as start: new period used at once
        iAddr  = 2'd0;
        iWdata = 16'd4;
        iWe    = 1'b1;
        iStart = 1'b1;
        tick();
        iWe    = 1'b0;
        iStart = 1'b0;
        capture(20);
        chk("coinc_end0", int'(end_v[0]), 0);
        chk("coinc_end4", int'(end_v[4]), 1);
        chk("coinc_end_cnt", end_cnt, 3);
        chk("coinc_pwm_cnt", pwm_cnt, 15);
        chk("coinc_pwm15", int'(pwm_v[15]), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
